ghost_collision_unit: RTL and testbench

Frame-synchronous collision manager for NUM_GHOSTS ghosts against Pac-Man, replacing the single-pair combinational box check. On each frame tick it snapshots all positions, scans one ghost per cycle, and records hits. It then reports one event per hit ghost over a valid/ready channel to the game-state controller. Per-ghost hold-off stops one sustained contact from producing an event every frame.

---
 rtl/ghost_collision_unit_if.sv | 25 ++
 rtl/ghost_collision_unit.sv | 208 ++++++++++++++++++++
 tb/tb_ghost_collision_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ghost_collision_unit_if.sv
// ghost_collision_unit_if
//   Event channel from the collision unit to the game-state controller.
//   One event is transferred on each cycle where evt_valid and evt_ready are both high.
//
//   Signals:
//     evt_valid  master->slave  event available
//     evt_ready  slave->master  consumer accepts the event
//     evt_id     master->slave  index of the ghost in the event
//     evt_eaten  master->slave  1 = ghost eaten, 0 = Pac-Man killed
//
//   NUM_GHOSTS must match the value given to the attached ghost_collision_unit,
//   because it sets the width of evt_id.
interface ghost_collision_unit_if #(
    parameter int NUM_GHOSTS = 4
);
    localparam int ID_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_eaten;

    modport master (output evt_valid, output evt_id, output evt_eaten, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_eaten, output evt_ready);
endinterface

// File: rtl/ghost_collision_unit.sv
// ghost_collision_unit
//   Frame-synchronous collision manager for NUM_GHOSTS ghosts against Pac-Man.
//   A frame tick snapshots all positions. The unit then scans one ghost per cycle and
//   reports each hit ghost as one event over a valid/ready channel. The reports go out
//   in ascending ghost index order.
//
//   Optional feature macro: COLLISION_HOLDOFF_EN
//     defined   - a ghost that produced an event is ignored for the next
//                 HOLDOFF_FRAMES accepted ticks.
//     undefined - no hold counters; every scan reports every ghost in contact.
//
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     frame_tick            one-cycle pulse that starts a scan
//     pacman_x/y            Pac-Man position
//     ghost_x/y             packed ghost positions, ghost i at [i*COORD_W +: COORD_W]
//     ghost_en              ghost active (an inactive ghost never hits)
//     ghost_fright          ghost frightened (a hit means the ghost is eaten)
//     evt                   event channel (master side)
//     busy                  FSM not in IDLE
//     scan_done             one-cycle pulse when a frame is fully processed
//     overrun               sticky, set when frame_tick arrives while busy
module ghost_collision_unit #(
    parameter int NUM_GHOSTS     = 4,
    parameter int COORD_W        = 10,
    parameter int HIT_SIZE       = 16,
    parameter int HOLDOFF_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic [COORD_W-1:0]            pacman_x,
    input  logic [COORD_W-1:0]            pacman_y,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
    input  logic [NUM_GHOSTS-1:0]         ghost_en,
    input  logic [NUM_GHOSTS-1:0]         ghost_fright,
    ghost_collision_unit_if.master        evt,
    output logic                          busy,
    output logic                          scan_done,
    output logic                          overrun
);
    localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t                               state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [NUM_GHOSTS-1:0]                hit_q, hit_d;       // ghosts still to report
    logic [NUM_GHOSTS-1:0]                type_q, type_d;     // latched event type per ghost
    logic [NUM_GHOSTS-1:0]                elig_q, elig_d;
    logic [NUM_GHOSTS-1:0]                fright_q, fright_d;
    logic [COORD_W-1:0]                   px_q, px_d, py_q, py_d;
    logic [NUM_GHOSTS-1:0][COORD_W-1:0]   gx_q, gx_d, gy_q, gy_d;
    logic                                 scan_done_q, scan_done_d;
    logic                                 overrun_q, overrun_d;

`ifdef COLLISION_HOLDOFF_EN
    localparam int HOLD_W = $clog2(HOLDOFF_FRAMES + 1);
    logic [NUM_GHOSTS-1:0][HOLD_W-1:0]    hold_q, hold_d;
`endif

    // Distance check for the ghost selected by idx_q.
    logic [COORD_W-1:0] gx_cur, gy_cur, dx, dy;
    logic               hit_now;

    always_comb begin
        gx_cur  = gx_q[idx_q];
        gy_cur  = gy_q[idx_q];
        // Subtract the smaller operand from the larger, so 0 vs max is a large distance, not 1.
        dx      = (gx_cur >= px_q) ? (gx_cur - px_q) : (px_q - gx_cur);
        dy      = (gy_cur >= py_q) ? (gy_cur - py_q) : (py_q - gy_cur);
        hit_now = elig_q[idx_q] && (32'(dx) < HIT_SIZE) && (32'(dy) < HIT_SIZE);
    end

    // The lowest pending ghost is reported first.
    logic [IDX_W-1:0] sel_id;

    always_comb begin
        sel_id = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (hit_q[i]) sel_id = IDX_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hit_d       = hit_q;
        type_d      = type_q;
        elig_d      = elig_q;
        fright_d    = fright_q;
        px_d        = px_q;
        py_d        = py_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        scan_done_d = 1'b0;
        // A tick that arrives outside IDLE is dropped and flagged.
        overrun_d   = overrun_q | (frame_tick && (state_q != IDLE));
`ifdef COLLISION_HOLDOFF_EN
        hold_d      = hold_q;
`endif

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    px_d     = pacman_x;
                    py_d     = pacman_y;
                    gx_d     = ghost_x;
                    gy_d     = ghost_y;
                    fright_d = ghost_fright;
                    for (int i = 0; i < NUM_GHOSTS; i++) begin
`ifdef COLLISION_HOLDOFF_EN
                        // Eligibility uses the count from before this tick's decrement.
                        // A ghost loaded with N therefore sits out exactly N ticks.
                        elig_d[i] = ghost_en[i] && (hold_q[i] == '0);
                        if (hold_q[i] != '0) hold_d[i] = hold_q[i] - HOLD_W'(1);
`else
                        elig_d[i] = ghost_en[i];
`endif
                    end
                    idx_d   = '0;
                    hit_d   = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (hit_now) begin
                    hit_d[idx_q]  = 1'b1;
                    type_d[idx_q] = fright_q[idx_q];
`ifdef COLLISION_HOLDOFF_EN
                    hold_d[idx_q] = HOLD_W'(HOLDOFF_FRAMES);
`endif
                end
                if (idx_q == LAST_IDX) begin
                    // hit_d includes the result for the final ghost.
                    if (hit_d != '0) begin
                        state_d = REPORT;
                    end else begin
                        scan_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            REPORT: begin
                if (evt.evt_ready) begin
                    hit_d[sel_id] = 1'b0;
                    if (hit_d == '0) begin
                        scan_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hit_q       <= '0;
            type_q      <= '0;
            elig_q      <= '0;
            fright_q    <= '0;
            px_q        <= '0;
            py_q        <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            scan_done_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef COLLISION_HOLDOFF_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hit_q       <= hit_d;
            type_q      <= type_d;
            elig_q      <= elig_d;
            fright_q    <= fright_d;
            px_q        <= px_d;
            py_q        <= py_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            scan_done_q <= scan_done_d;
            overrun_q   <= overrun_d;
`ifdef COLLISION_HOLDOFF_EN
            hold_q      <= hold_d;
`endif
        end
    end

    // The event fields only change on a handshake, because the pending mask only
    // changes then. evt_eaten is gated so that a stale type does not show when idle.
    assign evt.evt_valid = (state_q == REPORT);
    assign evt.evt_id    = sel_id;
    assign evt.evt_eaten = (state_q == REPORT) && type_q[sel_id];
    assign busy          = (state_q != IDLE);
    assign scan_done     = scan_done_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_ghost_collision_unit.sv
module tb_ghost_collision_unit;
    localparam int N  = 4;
    localparam int CW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_tick = 1'b0;
    logic [CW-1:0]   pacman_x = '0, pacman_y = '0;
    logic [N*CW-1:0] ghost_x = '0, ghost_y = '0;
    logic [N-1:0]    ghost_en = '0, ghost_fright = '0;
    logic            busy, scan_done, overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;
        int eaten;
    } evt_t;

    evt_t exp_q[$];
    evt_t obs_q[$];

    ghost_collision_unit_if #(.NUM_GHOSTS(N)) evt_bus ();

    ghost_collision_unit #(
        .NUM_GHOSTS(N), .COORD_W(CW), .HIT_SIZE(16), .HOLDOFF_FRAMES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .pacman_x(pacman_x), .pacman_y(pacman_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .ghost_en(ghost_en), .ghost_fright(ghost_fright),
        .evt(evt_bus),
        .busy(busy), .scan_done(scan_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic set_ghost(input int i, input int x, input int y, input bit en, input bit fr);
        ghost_x[i*CW +: CW] = x[CW-1:0];
        ghost_y[i*CW +: CW] = y[CW-1:0];
        ghost_en[i]         = en;
        ghost_fright[i]     = fr;
    endtask

    task automatic push_exp(input int id, input int eaten);
        evt_t e;
        e.id = id;
        e.eaten = eaten;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_tick = 1'b0;
        evt_bus.evt_ready = 1'b0;
        ghost_en = '0;
        ghost_fright = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Drive one tick. Then step through the cycles and collect handshaked events into obs_q.
    // cyc=1 is the cycle right after the edge that samples the tick.
    // evt_ready stays low for the first rdy_lo cycles of evt_valid.
    // done_cyc is the cycle where scan_done is seen, or -1 if the budget runs out.
    task automatic run_frame(input int rdy_lo, output int done_cyc, output int unstable);
        int vcnt = 0;
        bit pstall = 0;
        int pid = 0, pe = 0;
        evt_t o;
        done_cyc = -1;
        unstable = 0;
        obs_q.delete();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (scan_done) begin
                done_cyc = cyc;
                break;
            end
            if (evt_bus.evt_valid) begin
                vcnt++;
                if (pstall && (int'(evt_bus.evt_id) != pid || int'(evt_bus.evt_eaten) != pe))
                    unstable++;
                evt_bus.evt_ready = (vcnt > rdy_lo);
                if (evt_bus.evt_ready) begin
                    o.id = int'(evt_bus.evt_id);
                    o.eaten = int'(evt_bus.evt_eaten);
                    obs_q.push_back(o);
                end
                pstall = !evt_bus.evt_ready;
                pid = int'(evt_bus.evt_id);
                pe = int'(evt_bus.evt_eaten);
            end else begin
                evt_bus.evt_ready = 1'b0;
                pstall = 0;
            end
        end
        evt_bus.evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({evt_bus.evt_valid, evt_bus.evt_id, evt_bus.evt_eaten, busy, scan_done, overrun} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {evt_bus.evt_valid, evt_bus.evt_id, evt_bus.evt_eaten, busy, scan_done, overrun});
        end
    endtask

    task automatic test_boundary();
        int d, u;
        evt_t e, o;
        do_reset();
        pacman_x = 100; pacman_y = 100;
        set_ghost(1, 116, 100, 1, 0);
        run_frame(0, d, u);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL bound16_events got=%0d want=0", obs_q.size()); end
        total++; if (d != 5) begin bad++; $display("FAIL bound16_done got=%0d want=5", d); end

        set_ghost(1, 115, 100, 1, 0);
        push_exp(1, 0);
        run_frame(0, d, u);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bound15_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.id != e.id || o.eaten != e.eaten) begin bad++; $display("FAIL bound15_evt got=%0d/%0d want=%0d/%0d", o.id, o.eaten, e.id, e.eaten); end
        end
        exp_q.delete();
        total++; if (d != 6) begin bad++; $display("FAIL bound15_done got=%0d want=6", d); end

        ghost_en = '0;
        pacman_x = 1023; pacman_y = 1023;
        set_ghost(0, 0, 0, 1, 0);
        run_frame(0, d, u);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL nowrap_events got=%0d want=0", obs_q.size()); end
        total++; if (d != 5) begin bad++; $display("FAIL nowrap_done got=%0d want=5", d); end
    endtask

    task automatic test_back_to_back();
        int d, u;
        evt_t e, o;
        do_reset();
        pacman_x = 200; pacman_y = 50;
        set_ghost(2, 210, 50, 1, 1);
        set_ghost(3, 195, 45, 1, 0);
        push_exp(2, 1);
        push_exp(3, 0);
        run_frame(3, d, u);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.id != e.id || o.eaten != e.eaten) begin bad++; $display("FAIL b2b_evt got=%0d/%0d want=%0d/%0d", o.id, o.eaten, e.id, e.eaten); end
        end
        exp_q.delete();
        total++; if (u != 0) begin bad++; $display("FAIL b2b_stable got=%0d changes want=0", u); end
        total++; if (d != 10) begin bad++; $display("FAIL b2b_done got=%0d want=10", d); end
    endtask

    task automatic test_holdoff();
        int d, u, want;
        do_reset();
        pacman_x = 400; pacman_y = 400;
        set_ghost(0, 400, 400, 1, 0);
        for (int t = 1; t <= 6; t++) begin
`ifdef COLLISION_HOLDOFF_EN
            want = (t == 1 || t == 5) ? 1 : 0;
`else
            want = 1;
`endif
            run_frame(0, d, u);
            total++;
            if (obs_q.size() != want) begin bad++; $display("FAIL holdoff_tick%0d got=%0d want=%0d", t, obs_q.size(), want); end
        end
    endtask

    task automatic test_overrun();
        int done_at = -1;
        bit busy_late = 0;
        do_reset();
        pacman_x = 500; pacman_y = 500;
        set_ghost(0, 500, 500, 0, 0);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc == 2) frame_tick = 1'b1;
            if (cyc == 3) begin
                frame_tick = 1'b0;
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
            end
            if (scan_done && done_at < 0) done_at = cyc;
            if (cyc >= 5 && busy) busy_late = 1;
        end
        total++; if (done_at != 5) begin bad++; $display("FAIL overrun_done got=%0d want=5", done_at); end
        total++; if (busy_late) begin bad++; $display("FAIL overrun_dropped busy after scan got=1 want=0"); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
    endtask

    task automatic test_disabled();
        int d, u;
        do_reset();
        pacman_x = 300; pacman_y = 300;
        set_ghost(0, 300, 300, 0, 0);
        set_ghost(1, 700, 700, 1, 0);
        set_ghost(2, 10, 900, 1, 1);
        run_frame(0, d, u);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL disabled_events got=%0d want=0", obs_q.size()); end
        total++; if (d != N + 1) begin bad++; $display("FAIL disabled_done got=%0d want=%0d", d, N + 1); end
    endtask

    task automatic test_reset_mid_report();
        int d, u;
        evt_t e, o;
        do_reset();
        pacman_x = 100; pacman_y = 100;
        set_ghost(0, 105, 110, 1, 0);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== 2'd0) begin
            bad++; $display("FAIL midrst_pending got=%b/%0d want=1/0", evt_bus.evt_valid, evt_bus.evt_id);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({evt_bus.evt_valid, evt_bus.evt_id, evt_bus.evt_eaten, busy, scan_done, overrun} !== 6'b0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b want=000000",
                     {evt_bus.evt_valid, evt_bus.evt_id, evt_bus.evt_eaten, busy, scan_done, overrun});
        end
        push_exp(0, 0);
        run_frame(0, d, u);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.id != e.id || o.eaten != e.eaten) begin bad++; $display("FAIL midrst_evt got=%0d/%0d want=%0d/%0d", o.id, o.eaten, e.id, e.eaten); end
        end
        exp_q.delete();
        total++; if (d != 6) begin bad++; $display("FAIL midrst_done got=%0d want=6", d); end
    endtask

    // Random frames checked against an independent distance model.
    // A reset before each frame clears any hold-off state.
    task automatic test_random();
        int d, u, px, py, gx, gy, adx, ady, nhit, rlo;
        bit en, fr;
        evt_t e, o;
        for (int f = 0; f < 10; f++) begin
            do_reset();
            px = $urandom_range(1000, 20);
            py = $urandom_range(1000, 20);
            pacman_x = px[CW-1:0]; pacman_y = py[CW-1:0];
            nhit = 0;
            for (int i = 0; i < N; i++) begin
                gx = px + $urandom_range(40, 0) - 20;
                gy = py + $urandom_range(40, 0) - 20;
                en = ($urandom_range(3, 0) != 0);
                fr = $urandom_range(1, 0);
                set_ghost(i, gx, gy, en, fr);
                adx = (gx > px) ? gx - px : px - gx;
                ady = (gy > py) ? gy - py : py - gy;
                if (en && adx < 16 && ady < 16) begin
                    push_exp(i, fr);
                    nhit++;
                end
            end
            rlo = $urandom_range(2, 0);
            run_frame(rlo, d, u);
            total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", f, obs_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                total++;
                if (o.id != e.id || o.eaten != e.eaten) begin bad++; $display("FAIL rand%0d_evt got=%0d/%0d want=%0d/%0d", f, o.id, o.eaten, e.id, e.eaten); end
            end
            exp_q.delete();
            total++;
            if (d != ((nhit == 0) ? N + 1 : N + 1 + rlo + nhit)) begin
                bad++; $display("FAIL rand%0d_done got=%0d want=%0d", f, d, (nhit == 0) ? N + 1 : N + 1 + rlo + nhit);
            end
        end
    endtask

    initial begin
        evt_bus.evt_ready = 1'b0;
        test_reset();
        test_boundary();
        test_back_to_back();
        test_holdoff();
        test_overrun();
        test_disabled();
        test_reset_mid_report();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
